// File: rtl/serial_negate_rx_pkg.sv
// Shared definitions for the bit-serial 2's-complement link: receiver FSM
// state encodings and the default frame width.
package serial_negate_rx_pkg;

  localparam int COMPL_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/serial_negate_rx_bit.sv
// One-bit serial negation cell: remembers whether a 1 has passed in the current
// frame and inverts every later bit (copy through the first 1, invert after).
module serial_negate_bit (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic sin,
  output logic dout_bit
);

  logic seen_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= (clr ? 1'b0 : seen_one) | sin;
    end
  end

  // clr marks bit 0, which must see a fresh (cleared) history
  assign dout_bit = (seen_one & ~clr) ? ~sin : sin;

endmodule

// File: rtl/serial_negate_rx.sv
// Receive end of the bit-serial 2's-complement link: deserialises an LSB-first
// frame, re-negates it on the fly and offers raw and negated words on valid/ready.
module serial_negate_rx
  import serial_negate_rx_pkg::*;
#(
  parameter int WIDTH = COMPL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_raw,
  output logic             dout_ovf,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] raw_sr, dec_sr;
  logic [WIDTH-1:0] raw_next, dec_next;
  logic             first_bit, take_bit, last_bit, dec_bit, slot_free;

  assign first_bit = sin_valid & sin_start;
  assign take_bit  = sin_valid & (sin_start | (state == ST_RECV));
  assign last_bit  = sin_valid & ~sin_start & (state == ST_RECV) &
                     (cnt == CW'(WIDTH - 1));
  assign slot_free = ~dout_valid | dout_ready;

  assign raw_next  = {sin, raw_sr[WIDTH-1:1]};
  assign dec_next  = {dec_bit, dec_sr[WIDTH-1:1]};
  assign busy      = (state == ST_RECV);

  serial_negate_bit u_neg (
    .clk      (clk),
    .reset    (reset),
    .clr      (first_bit),
    .en       (take_bit),
    .sin      (sin),
    .dout_bit (dec_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (first_bit) state_next = ST_RECV;
      ST_RECV: if (last_bit)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A restart simply overwrites the shift registers; WIDTH captures refill them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      raw_sr <= '0;
      dec_sr <= '0;
    end else if (take_bit) begin
      raw_sr <= raw_next;
      dec_sr <= dec_next;
      cnt    <= first_bit ? CW'(1) : (last_bit ? '0 : cnt + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_raw   <= '0;
      dout_ovf   <= 1'b0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= last_bit & ~slot_free;
      frame_err <= first_bit & (state == ST_RECV);
      if (last_bit && slot_free) begin
        dout       <= dec_next;
        dout_raw   <= raw_next;
        dout_ovf   <= (raw_next == MIN_WORD);
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_negate_rx.sv
// Directed bench for serial_negate_rx: an arithmetic reference model checked every
// cycle, plus literal expectations on the words delivered and the pulse counts.
module tb_serial_negate_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sin = 1'b0, sin_valid = 1'b0, sin_start = 1'b0, dout_ready = 1'b1;
  logic [W-1:0] dout, dout_raw;
  logic         dout_ovf, dout_valid, busy, overrun, frame_err;

  int errors = 0;
  int checks = 0;

  serial_negate_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .dout(dout), .dout_raw(dout_raw), .dout_ovf(dout_ovf), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: accumulate the frame as a number, negate arithmetically.
  int           m_cnt;
  logic         m_busy, m_v, m_ovr, m_ferr, m_ovf;
  logic [W-1:0] m_acc, m_raw, m_neg;

  always @(posedge clk or negedge reset) begin
    logic done;
    if (!reset) begin
      m_cnt = 0; m_busy = 0; m_v = 0; m_ovr = 0; m_ferr = 0;
      m_acc = 0; m_raw = 0; m_neg = 0; m_ovf = 0;
    end else begin
      done = 0; m_ovr = 0; m_ferr = 0;
      if (sin_valid) begin
        if (sin_start) begin
          m_ferr = m_busy;
          m_acc = W'(sin);
          m_cnt = 1;
          m_busy = 1;
        end else if (m_busy) begin
          m_acc = m_acc | (W'(sin) << m_cnt);
          m_cnt++;
          if (m_cnt == W) begin done = 1; m_busy = 0; end
        end
      end
      if (done) begin
        if (!m_v || dout_ready) begin
          m_v = 1; m_raw = m_acc; m_neg = W'(0 - int'(m_acc));
          m_ovf = (m_acc == 8'h80);
        end else begin
          m_ovr = 1;
        end
      end else if (dout_ready) begin
        m_v = 0;
      end
    end
  end

  // Per-cycle compare, plus a log of every word the DUT presents.
  logic [W-1:0] got_neg[$], got_raw[$];
  logic         got_ovf[$];
  logic         prev_v = 0;
  int           ovr_count = 0, ferr_count = 0;

  always @(posedge clk) begin
    #5;
    check("valid", dout_valid, m_v);
    check("busy", busy, m_busy);
    check("overrun", overrun, m_ovr);
    check("frame_err", frame_err, m_ferr);
    if (m_v) begin
      check("dout", dout, m_neg);
      check("dout_raw", dout_raw, m_raw);
      check("dout_ovf", dout_ovf, m_ovf);
    end
    if (dout_valid && (!prev_v || dout_ready)) begin
      got_neg.push_back(dout); got_raw.push_back(dout_raw); got_ovf.push_back(dout_ovf);
    end
    if (overrun) ovr_count++;
    if (frame_err) ferr_count++;
    prev_v = dout_valid;
  end

  task automatic send_bits(input logic [W-1:0] v, input int nbits, input int stall_at);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == stall_at) begin
        sin_valid = 0; sin_start = 0;
        repeat (3) begin
          @(negedge clk);
          check("busy_stall", busy, 1'b1);
        end
      end
      sin = v[i]; sin_valid = 1; sin_start = (i == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin_valid = 0; sin_start = 0; sin = 0;
    end
  endtask

  logic [W-1:0] e_neg[8] = '{8'h05, 8'h00, 8'h80, 8'hF4, 8'hFF, 8'hFD, 8'hF0, 8'h01};
  logic [W-1:0] e_raw[8] = '{8'hFB, 8'h00, 8'h80, 8'h0C, 8'h01, 8'h03, 8'h10, 8'hFF};
  logic         e_ovf[8] = '{0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", dout_valid, 1'b0);
    check("reset_dout", dout, 8'h00);
    reset = 1;
    idle(2);

    send_bits(8'hFB, W, -1);                 // 1
    idle(3);
    send_bits(8'h00, W, -1);                 // 2: back-to-back
    send_bits(8'h80, W, -1);
    idle(3);
    send_bits(8'h0C, W, 4);                  // 3: stall mid-frame
    idle(3);
    dout_ready = 0;                          // 4: output full
    send_bits(8'h01, W, -1);
    send_bits(8'h02, W, -1);
    idle(3);
    check("ovr_count", ovr_count, 1);
    check("hold_dout", dout, 8'hFF);
    @(negedge clk); dout_ready = 1;
    @(negedge clk);
    check("drain_valid", dout_valid, 1'b0);
    idle(2);
    send_bits(8'hA5, 4, -1);                 // 5: restart mid-frame
    send_bits(8'h03, W, -1);
    idle(3);
    check("ferr_count", ferr_count, 1);
    dout_ready = 0;                          // 6: reset with word held
    send_bits(8'h10, W, -1);
    send_bits(8'h55, 3, -1);
    #3 reset = 0;
    #1;
    check("arst_valid", dout_valid, 1'b0);
    check("arst_dout", dout, 8'h00);
    check("arst_raw", dout_raw, 8'h00);
    check("arst_busy", busy, 1'b0);
    idle(2);
    reset = 1; dout_ready = 1;
    idle(1);
    send_bits(8'hFF, W, -1);
    idle(4);

    check("word_count", got_neg.size(), 8);
    for (int i = 0; i < 8 && i < got_neg.size(); i++) begin
      check($sformatf("word%0d_neg", i), got_neg[i], e_neg[i]);
      check($sformatf("word%0d_raw", i), got_raw[i], e_raw[i]);
      check($sformatf("word%0d_ovf", i), got_ovf[i], e_ovf[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
